// File: rtl/vmem_arbiter_if.sv
// Pixel-writer handshake into the frame-buffer arbiter.
// The producer drives master; the arbiter is the slave.
interface vmem_arbiter_if #(
    parameter int unsigned H_W    = 10,
    parameter int unsigned V_W    = 9,
    parameter int unsigned DATA_W = 24
);
    logic              wr_valid;
    logic              wr_ready;
    logic [H_W-1:0]    wr_h_addr;
    logic [V_W-1:0]    wr_v_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_h_addr,
        output wr_v_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_h_addr,
        input  wr_v_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vmem_arbiter.sv
// Frame-buffer port arbiter: scanout reads have strict priority, queued pixel
// writes drain into the single-port RAM only on cycles scanout leaves free.
module vmem_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned H_W        = 10,
    parameter int unsigned V_W        = 9,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned STALL_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vga_rd_en,
    input  logic [H_W-1:0]                vga_h_addr,
    input  logic [V_W-1:0]                vga_v_addr,
    output logic [DATA_W-1:0]             vga_data,
    vmem_arbiter_if.slave                 wr,
    output logic [H_W+V_W-1:0]            mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [STALL_W-1:0]            stall_cnt
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned A_W   = H_W + V_W;
    localparam int unsigned ENT_W = A_W + DATA_W;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [STALL_W-1:0] stall_q;
    gnt_e               gnt_q;
    gnt_e               gnt_d;

    logic               empty;
    logic               full;
    logic               ready_c;
    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   head;

    assign empty   = (level_q == LW'(0));
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign ready_c = rst & ~full;
    assign push    = wr.wr_valid & ready_c;
    assign pop     = (gnt_d == GNT_WR);
    assign head    = fifo_q[rd_ptr_q];

    assign wr.wr_ready = ready_c;
    assign fifo_level  = level_q;
    assign stall_cnt   = stall_q;
    assign vga_data    = (gnt_q == GNT_RD) ? mem_rdata : DATA_W'(0);

    // Grant for this cycle; everything held off while reset is asserted.
    always_comb begin
        gnt_d = GNT_IDLE;
        if (rst) begin
            if (vga_rd_en) begin
                gnt_d = GNT_RD;
            end else if (!empty) begin
                gnt_d = GNT_WR;
            end
        end
    end

    always_comb begin
        mem_addr  = A_W'(0);
        mem_we    = 1'b0;
        mem_wdata = DATA_W'(0);
        case (gnt_d)
            GNT_RD: begin
                mem_addr = {vga_h_addr, vga_v_addr};
            end
            GNT_WR: begin
                mem_addr  = head[ENT_W-1:DATA_W];
                mem_we    = 1'b1;
                mem_wdata = head[DATA_W-1:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
            stall_q  <= STALL_W'(0);
            gnt_q    <= GNT_IDLE;
        end else begin
            gnt_q <= gnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= {wr.wr_h_addr, wr.wr_v_addr, wr.wr_data};
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // Blocked write cycle: scanout owns the port while writes wait.
            if (vga_rd_en && !empty && (stall_q != {STALL_W{1'b1}})) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter with a behavioural synchronous RAM model.
module tb_vmem_arbiter;
    localparam int unsigned H_W = 10;
    localparam int unsigned V_W = 9;
    localparam int unsigned D_W = 24;
    localparam int unsigned A_W = H_W + V_W;

    logic           clk = 1'b0;
    logic           rst;
    logic           vga_rd_en;
    logic [H_W-1:0] vga_h_addr;
    logic [V_W-1:0] vga_v_addr;
    logic [D_W-1:0] vga_data;
    logic [A_W-1:0] mem_addr;
    logic           mem_we;
    logic [D_W-1:0] mem_wdata;
    logic [D_W-1:0] mem_rdata;
    logic [2:0]     fifo_level;
    logic [3:0]     stall_cnt;

    logic           pre_we;
    logic [A_W-1:0] pre_addr;
    logic [D_W-1:0] pre_data;
    logic [D_W-1:0] ram [0:(1<<A_W)-1];

    int n_cmp = 0;
    int n_fail = 0;

    vmem_arbiter_if #(.H_W(H_W), .V_W(V_W), .DATA_W(D_W)) wif ();

    vmem_arbiter #(
        .FIFO_DEPTH(4), .H_W(H_W), .V_W(V_W), .DATA_W(D_W), .STALL_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_rd_en(vga_rd_en), .vga_h_addr(vga_h_addr), .vga_v_addr(vga_v_addr),
        .vga_data(vga_data), .wr(wif),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; vga_rd_en = 1'b0;
        wif.wr_valid = 1'b1; wif.wr_h_addr = 10'd9; wif.wr_v_addr = 9'd9; wif.wr_data = 24'hBADBAD;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (wif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready c%0d: got %b want 0", c, wif.wr_ready); end
            n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we c%0d: got %b want 0", c, mem_we); end
            n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level c%0d: got %0d want 0", c, fifo_level); end
            n_cmp++; if (vga_data !== 24'h0) begin n_fail++; $display("FAIL reset_vga_data c%0d: got %h want 0", c, vga_data); end
        end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        wif.wr_valid = 1'b0; rst = 1'b1;
        tick();
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_no_push: got %0d want 0", fifo_level); end
        n_cmp++; if (wif.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", wif.wr_ready); end
    endtask

    task automatic test_read_latency();
        pre_we = 1'b1; pre_addr = {10'd5, 9'd7}; pre_data = 24'hA1B2C3;
        tick();
        pre_we = 1'b0;
        vga_rd_en = 1'b1; vga_h_addr = 10'd5; vga_v_addr = 9'd7;
        settle();
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== {10'd5, 9'd7}) begin n_fail++; $display("FAIL rd_mem_addr: got %h want %h", mem_addr, {10'd5, 9'd7}); end
        n_cmp++; if (vga_data !== 24'h0) begin n_fail++; $display("FAIL rd_data_early: got %h want 0", vga_data); end
        tick();
        vga_rd_en = 1'b0;
        settle();
        n_cmp++; if (vga_data !== 24'hA1B2C3) begin n_fail++; $display("FAIL rd_data_t1: got %h want a1b2c3", vga_data); end
        tick();
        n_cmp++; if (vga_data !== 24'h0) begin n_fail++; $display("FAIL rd_data_t2: got %h want 0", vga_data); end
    endtask

    task automatic test_drain();
        logic [D_W-1:0] dat [3];
        dat[0] = 24'h000011; dat[1] = 24'h000022; dat[2] = 24'h000033;
        vga_rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wif.wr_valid = (k < 3);
            if (k < 3) begin
                wif.wr_h_addr = H_W'(k + 1); wif.wr_v_addr = V_W'(k + 1); wif.wr_data = dat[k];
            end
            settle();
            if (k >= 1 && k <= 3) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== {H_W'(k), V_W'(k)} || mem_wdata !== dat[k-1])
                    begin n_fail++; $display("FAIL drain_wr%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", k, mem_we, mem_addr, mem_wdata, {H_W'(k), V_W'(k)}, dat[k-1]); end
                n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL drain_level%0d: got %0d want 1", k, fifo_level); end
            end else if (k == 4) begin
                n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL drain_idle_we: got %b want 0", mem_we); end
                n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL drain_level_end: got %0d want 0", fifo_level); end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (ram[{H_W'(k + 1), V_W'(k + 1)}] !== dat[k]) begin n_fail++; $display("FAIL drain_ram%0d: got %h want %h", k, ram[{H_W'(k + 1), V_W'(k + 1)}], dat[k]); end
        end
    endtask

    task automatic test_full_priority();
        vga_rd_en = 1'b1; vga_h_addr = 10'd0; vga_v_addr = 9'd0;
        for (int k = 0; k < 5; k++) begin
            wif.wr_valid = 1'b1; wif.wr_h_addr = H_W'(10 + k); wif.wr_v_addr = V_W'(20 + k); wif.wr_data = D_W'(32'hD0 + k);
            settle();
            n_cmp++; if (fifo_level !== 3'(k)) begin n_fail++; $display("FAIL full_level%0d: got %0d want %0d", k, fifo_level, k); end
            n_cmp++; if (wif.wr_ready !== (k < 4)) begin n_fail++; $display("FAIL full_ready%0d: got %b want %b", k, wif.wr_ready, (k < 4)); end
            n_cmp++; if (stall_cnt !== 4'((k == 0) ? 0 : k - 1)) begin n_fail++; $display("FAIL full_stall%0d: got %0d want %0d", k, stall_cnt, (k == 0) ? 0 : k - 1); end
            n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL full_we_blocked%0d: got %b want 0", k, mem_we); end
            tick();
        end
        vga_rd_en = 1'b0; wif.wr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            if (k < 4) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== {H_W'(10 + k), V_W'(20 + k)} || mem_wdata !== D_W'(32'hD0 + k))
                    begin n_fail++; $display("FAIL full_emit%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", k, mem_we, mem_addr, mem_wdata, {H_W'(10 + k), V_W'(20 + k)}, D_W'(32'hD0 + k)); end
                n_cmp++; if (wif.wr_ready !== (k > 0)) begin n_fail++; $display("FAIL full_ready_drain%0d: got %b want %b", k, wif.wr_ready, (k > 0)); end
            end else begin
                n_cmp++; if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL full_done: got we=%b lvl=%0d want we=0 lvl=0", mem_we, fifo_level); end
                n_cmp++; if (stall_cnt !== 4'd4) begin n_fail++; $display("FAIL full_stall_hold: got %0d want 4", stall_cnt); end
            end
            tick();
        end
    endtask

    task automatic test_simul_push_pop();
        logic [D_W-1:0] dat [3];
        dat[0] = 24'hAAAA01; dat[1] = 24'hBBBB02; dat[2] = 24'hCCCC03;
        for (int k = 0; k < 6; k++) begin
            vga_rd_en = (k < 2);
            wif.wr_valid = (k < 3);
            if (k < 3) begin
                wif.wr_h_addr = H_W'(100 + k); wif.wr_v_addr = V_W'(200 + k); wif.wr_data = dat[k];
            end
            settle();
            if (k == 2 || k == 3) begin
                n_cmp++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL simul_level%0d: got %0d want 2", k, fifo_level); end
            end
            if (k >= 2 && k <= 4) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== {H_W'(100 + k - 2), V_W'(200 + k - 2)} || mem_wdata !== dat[k-2])
                    begin n_fail++; $display("FAIL simul_wr%0d: got we=%b a=%h d=%h want we=1 d=%h", k, mem_we, mem_addr, mem_wdata, dat[k-2]); end
            end
            if (k == 5) begin
                n_cmp++; if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL simul_done: got we=%b lvl=%0d want 0/0", mem_we, fifo_level); end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        vga_rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wif.wr_valid = 1'b1; wif.wr_h_addr = H_W'(300 + k); wif.wr_v_addr = V_W'(k); wif.wr_data = D_W'(32'h5000 + k);
            tick();
        end
        wif.wr_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall: got %0d want 15", stall_cnt); end
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_hold: got %0d want 15", stall_cnt); end
        n_cmp++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL sat_level: got %0d want 3", fifo_level); end
        rst = 1'b0; vga_rd_en = 1'b0;
        settle();
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL sat_rst_we: got %b want 0", mem_we); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_cmp++; if (mem_we !== 1'b0 || fifo_level !== 3'd0 || stall_cnt !== 4'd0)
                begin n_fail++; $display("FAIL sat_post_rst%0d: got we=%b lvl=%0d stall=%0d want 0/0/0", k, mem_we, fifo_level, stall_cnt); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; vga_rd_en = 1'b0; vga_h_addr = '0; vga_v_addr = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        wif.wr_valid = 1'b0; wif.wr_h_addr = '0; wif.wr_v_addr = '0; wif.wr_data = '0;
        test_reset();
        test_read_latency();
        test_drain();
        test_full_priority();
        test_simul_push_pop();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
